// File: rtl/voice_mixer_pkg.sv
// Shared voice/sample definitions for the operator core and the voice mixer.
package voice_mixer_pkg;

  localparam int unsigned NUM_VOICES  = 16;
  localparam int unsigned SUBSAMPLE_W = 16;

  typedef logic signed [15:0] sample_t;

  // Clamp a wide signed value into the 16-bit sample range.
  function automatic sample_t saturate(input logic signed [31:0] value);
    if (value > 32'sd32767) begin
      return 16'sh7fff;
    end else if (value < -32'sd32768) begin
      return 16'sh8000;
    end
    return sample_t'(value[15:0]);
  endfunction

endpackage

// File: rtl/voice_mixer_sample_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; reads zero while empty.
module sample_fifo
  import voice_mixer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = SUBSAMPLE_W
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Push,
  input  logic [WIDTH-1:0] i_WData,
  input  logic             i_Pop,
  output logic [WIDTH-1:0] o_RData,
  output logic             o_Full,
  output logic             o_Empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Status flags, accepted operations and next pointers.
  always_comb begin
    o_Empty = (wptr_q == rptr_q);
    o_Full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop  = i_Pop & ~o_Empty;
    // A full FIFO still takes a push when an entry leaves in the same cycle.
    do_push = i_Push & (~o_Full | do_pop);
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
    o_RData = o_Empty ? '0 : mem_q[rptr_q[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge i_Clock) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= i_WData;
    end
  end

endmodule

// File: rtl/voice_mixer.sv
// Sums one frame of voice subsamples, attenuates, saturates and buffers the mix.
module voice_mixer #(
  parameter int unsigned NUM_VOICES  = 16,
  parameter int unsigned ATTEN_SHIFT = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic signed [15:0] i_Subsample,
  input  logic               i_SubsampleValid,
  input  logic               i_SampleEnd,
  output logic signed [15:0] o_Sample,
  output logic               o_SampleValid,
  input  logic               i_SampleReady,
  output logic               o_Overrun,
  output logic               o_FrameError
);

  import voice_mixer_pkg::*;

  localparam int unsigned ACC_W     = SUBSAMPLE_W + $clog2(NUM_VOICES);
  localparam logic [4:0]  CntMax    = 5'd31;
  localparam logic [4:0]  VoicesCnt = 5'(NUM_VOICES);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sub_ext;
  logic signed [ACC_W-1:0] shifted;
  logic [4:0]              cnt_q, cnt_d, cnt_inc;
  sample_t                 mixed_q, mixed_d;
  logic                    push_q;
  logic                    overrun_q, overrun_d;
  logic                    frame_err_q, frame_err_d;
  logic                    frame_end;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    pop;

  // Accumulate the frame, form the mixed sample and update the sticky flags.
  always_comb begin
    sub_ext     = {{(ACC_W - SUBSAMPLE_W){i_Subsample[15]}}, i_Subsample};
    frame_end   = i_SubsampleValid & i_SampleEnd;
    cnt_inc     = (cnt_q == CntMax) ? CntMax : cnt_q + 5'd1;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    if (i_SubsampleValid) begin
      // The first subsample reloads, so no separate clear is needed between frames.
      acc_d = (cnt_q == 5'd0) ? sub_ext : acc_q + sub_ext;
      cnt_d = i_SampleEnd ? 5'd0 : cnt_inc;
    end
    shifted     = acc_d >>> ATTEN_SHIFT;
    mixed_d     = frame_end ? saturate(32'(shifted)) : mixed_q;
    pop         = i_SampleReady & ~fifo_empty;
    overrun_d   = overrun_q | (push_q & fifo_full & ~pop);
    frame_err_d = frame_err_q | (frame_end & (cnt_inc != VoicesCnt));
  end

  // Accumulator, counter, pending push and sticky flags.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      mixed_q     <= '0;
      push_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mixed_q     <= mixed_d;
      push_q      <= frame_end;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SUBSAMPLE_W)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Push  (push_q),
    .i_WData (mixed_q),
    .i_Pop   (pop),
    .o_RData (o_Sample),
    .o_Full  (fifo_full),
    .o_Empty (fifo_empty)
  );

  assign o_SampleValid = ~fifo_empty;
  assign o_Overrun     = overrun_q;
  assign o_FrameError  = frame_err_q;

endmodule
